if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage for the rv32 pipelined core. Drives the fetched instruction, its PC and PC+4, plus a valid bit, into the IF/ID pipeline register. Obeys that register's `suspend` and `flush` controls. Talks to instruction memory over a single-outstanding request/grant/response handshake, and redirects the PC on taken branches, jumps and traps.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC fetched first after reset; must be word-aligned.

Ports:
- `cpu_clk` in 1: the single clock; all state changes on its rising edge.
- `cpu_rst` in 1: reset, asynchronous and active-high.
- `suspend` in 1: IF/ID hold. Same signal as the IF/ID `suspend`.
- `flush` in 1: kill the instruction currently presented to IF/ID.
- `redirect` in 1: load a new fetch PC.
- `redirect_pc` in 32: target PC, sampled when `redirect`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, valid while `imem_req`=1.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: instruction word.
- `if_inst` out 32: instruction to IF/ID.
- `if_pc` out 32: PC of `if_inst`.
- `if_pc4` out 32: `if_pc`+4.
- `if_valid` out 1: `if_inst`/`if_pc`/`if_pc4` valid; feeds IF/ID `valid_in`.
- `if_misalign` out 1: present only with `IF_MISALIGN_EN`.

## Operation
- State: `pc` (next fetch address), FSM {IDLE, REQ, WAIT}, `discard` flag, output slot (`if_inst`, `if_pc`, `if_pc4`, `if_valid`).
- Reset values: `pc`=RESET_PC, state=IDLE, `discard`=0, `if_inst`=0, `if_pc`=0, `if_pc4`=0, `if_valid`=0, `if_misalign`=0. `imem_req` is 0 during reset.
- IDLE: unconditionally goes to REQ next cycle.
- REQ:
  - `imem_req` = !redirect && (!if_valid || !suspend); `imem_addr`=`pc`.
  - On `imem_req`&&`imem_gnt`: latch `pc` as the in-flight PC, `pc`<=`pc`+4 (mod 2^32), go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with `discard`=0: slot <= {`imem_rdata`, in-flight PC, in-flight PC+4}, `if_valid`<=1, go to REQ.
  - On `imem_rvalid` with `discard`=1: drop the data, clear `discard`, go to REQ.
- Slot release: `if_valid` clears when `!suspend` and the slot is not being reloaded that cycle. While `suspend`=1 the slot holds all values.
- The request gate guarantees a response always lands in an empty or simultaneously consumed slot. At most one request is outstanding.
- `flush`: `if_valid`<=0 next edge. Slot data is don't-care.
- `redirect`: `pc`<=`redirect_pc`. If a request is in flight (state WAIT, or granted in this same cycle), `discard`<=1. `if_valid`<=0. FSM goes to REQ, or stays in WAIT until the discarded response arrives.
- Priority: `redirect` > `flush` > `imem_rvalid` capture > `suspend` hold.
- `redirect` concurrent with `imem_rvalid` in WAIT: the response is discarded, `discard` stays 0, go to REQ.

## Timing
- Zero-wait memory (`gnt` in the request cycle, `rvalid` the next cycle):
  - REQ in cycle N, `rvalid` in N+1, `if_valid`=1 in N+2.
  - The next request issues in N+2.
  - Sustained rate is one instruction per 2 cycles.
- `redirect` in cycle N: `imem_req` for `redirect_pc` no earlier than N+1. Delayed further by any discarded in-flight response.
- All outputs except `imem_req` and `imem_addr` are registered. `imem_req` and `imem_addr` are combinational from state, `pc`, `if_valid`, `suspend` and `redirect`.
- `if_pc4` wraps: `if_pc`=32'hFFFF_FFFC gives `if_pc4`=0.
- Async reset mid-WAIT: everything returns to reset values. A late `imem_rvalid` after reset is ignored, because the FSM is in IDLE or REQ.

## Configuration
- `IF_MISALIGN_EN` defined:
  - On `redirect` with `redirect_pc[1:0]`!=0: `pc` is loaded anyway, `if_misalign`<=1 next edge, and the FSM enters a FAULT state with `imem_req`=0.
  - FAULT is left only by an aligned `redirect`, which clears `if_misalign` and goes to REQ, or by reset.
- `IF_MISALIGN_EN` undefined:
  - No `if_misalign` port and no FAULT state.
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr+32'h13 -> `imem_addr` sequence 0,4,8. `if_valid` first high 2 cycles after the first request. `if_pc4`=`if_pc`+4 each time.
- Memory delays `gnt` 3 cycles and `rvalid` 2 cycles -> `imem_req`/`imem_addr` held stable until `gnt`. `if_inst`=`imem_rdata` of the matching request.
- `suspend`=1 for 4 cycles while `if_valid`=1 -> slot unchanged, `imem_req`=0. After release, exactly one IF/ID consume and the next fetch starts.
- `redirect` to 32'h0000_0100 while in WAIT at `pc`=8 -> the response for 8 never appears on `if_inst`. The next `imem_addr`=32'h100.
- `flush`=1 with `if_valid`=1 -> `if_valid`=0 next cycle. `redirect` coincident with `imem_rvalid` -> data dropped.
- With `IF_MISALIGN_EN`: `redirect_pc`=32'h102 -> `if_misalign`=1, no requests. A later `redirect_pc`=32'h200 -> `if_misalign`=0 and fetch resumes at 32'h200.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake bundle for the fetch stage.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : word-aligned fetch address, valid while imem_req is high
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : response data valid
//   imem_rdata  : instruction word returned for the accepted request
// master modport is the fetch unit, slave modport is the instruction memory.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the rv32 pipeline.
// Fetches one instruction at a time over a single-outstanding request/grant/
// response handshake and presents it, with its PC and PC+4, to the IF/ID
// register. Honours IF/ID suspend/flush and redirects on branches/jumps/traps.
//
// Ports:
//   cpu_clk, cpu_rst : clock, asynchronous active-high reset
//   suspend          : IF/ID hold; the output slot keeps its contents
//   flush            : kill the instruction currently in the output slot
//   redirect         : load redirect_pc as the next fetch address
//   redirect_pc      : redirect target
//   imem             : instruction-memory handshake (if_fetch_unit_if.master)
//   if_inst/if_pc/if_pc4/if_valid : registered output slot to IF/ID
//   if_misalign      : misaligned-redirect fault flag (IF_MISALIGN_EN only)
//
// Build option IF_MISALIGN_EN: when defined, a misaligned redirect parks the
// unit in a FAULT state and raises if_misalign; when undefined the low two
// target bits are simply forced to zero.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  suspend,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           if_inst,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc4,
  output logic                  if_valid
`ifdef IF_MISALIGN_EN
  ,
  output logic                  if_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
`ifdef IF_MISALIGN_EN
    ,
    FAULT
`endif
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inflightPc_q;
  logic        discard_q;
  logic [31:0] inst_q;
  logic [31:0] slotPc_q;
  logic [31:0] slotPc4_q;
  logic        valid_q;
`ifdef IF_MISALIGN_EN
  logic        misalign_q;
  logic        redirMis_d;
`endif

  logic        reqGate_d;
  logic        fire_d;
  logic        pendingResp_d;
  logic [31:0] redirPc_d;

  // A request is only raised when the slot will be free by the time the
  // response lands, so a response never overwrites an unconsumed instruction.
  assign reqGate_d = (state_q == REQ) && !redirect && (!valid_q || !suspend);
  assign fire_d    = reqGate_d && imem.imem_gnt;

  assign imem.imem_req  = reqGate_d;
  assign imem.imem_addr = pc_q;

  // A response is still owed to us after this edge: discard must track it.
  assign pendingResp_d = ((state_q == WAIT) || discard_q) && !imem.imem_rvalid;

`ifdef IF_MISALIGN_EN
  assign redirPc_d  = redirect_pc;
  assign redirMis_d = |redirect_pc[1:0];
`else
  assign redirPc_d  = redirect_pc & ~32'd3;
`endif

  // Single sequential block: fetch FSM, PC, discard flag and output slot.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inflightPc_q <= 32'd0;
      discard_q    <= 1'b0;
      inst_q       <= 32'd0;
      slotPc_q     <= 32'd0;
      slotPc4_q    <= 32'd0;
      valid_q      <= 1'b0;
`ifdef IF_MISALIGN_EN
      misalign_q   <= 1'b0;
`endif
    end else if (redirect) begin
      pc_q      <= redirPc_d;
      valid_q   <= 1'b0;
      discard_q <= pendingResp_d;
`ifdef IF_MISALIGN_EN
      misalign_q <= redirMis_d;
      if (redirMis_d) begin
        state_q <= FAULT;
      end else begin
        state_q <= pendingResp_d ? WAIT : REQ;
      end
`else
      state_q <= pendingResp_d ? WAIT : REQ;
`endif
    end else begin
      // Output slot: flush beats capture, capture beats release/hold.
      if (flush) begin
        valid_q <= 1'b0;
      end else if ((state_q == WAIT) && imem.imem_rvalid && !discard_q) begin
        inst_q    <= imem.imem_rdata;
        slotPc_q  <= inflightPc_q;
        slotPc4_q <= inflightPc_q + 32'd4;
        valid_q   <= 1'b1;
      end else if (!suspend) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (fire_d) begin
            inflightPc_q <= pc_q;
            pc_q         <= pc_q + 32'd4;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            discard_q <= 1'b0;
            state_q   <= REQ;
          end
        end
        default: begin
          // FAULT: absorb a response left over from before the fault.
          if (imem.imem_rvalid) begin
            discard_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign if_inst  = inst_q;
  assign if_pc    = slotPc_q;
  assign if_pc4   = slotPc4_q;
  assign if_valid = valid_q;
`ifdef IF_MISALIGN_EN
  assign if_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit. A small instruction-memory model
// returns addr+32'h13 for every accepted request with programmable grant
// and response latency; each test task walks a hand-computed cycle timeline.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        suspend = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'd0;
  logic [31:0] ifInst;
  logic [31:0] ifPc;
  logic [31:0] ifPc4;
  logic        ifValid;
`ifdef IF_MISALIGN_EN
  logic        ifMisalign;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  // memory model knobs and state
  int          gntDelay = 0;
  int          rvDelay = 1;
  bit          memClear = 1'b0;
  bit          memPending = 1'b0;
  logic [31:0] memAddr = 32'd0;
  int          memRvCnt = 0;
  int          memAge = 0;
  logic        memGnt = 1'b0;
  logic        memRvalid = 1'b0;
  logic [31:0] memRdata = 32'd0;

  if_fetch_unit_if imemBus ();

  assign imemBus.imem_gnt    = memGnt;
  assign imemBus.imem_rvalid = memRvalid;
  assign imemBus.imem_rdata  = memRdata;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .cpu_clk     (clk),
    .cpu_rst     (rst),
    .suspend     (suspend),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .imem        (imemBus.master),
    .if_inst     (ifInst),
    .if_pc       (ifPc),
    .if_pc4      (ifPc4),
    .if_valid    (ifValid)
`ifdef IF_MISALIGN_EN
    ,
    .if_misalign (ifMisalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: observe the handshake of the cycle that just ended, then
  // drive grant/response for the new cycle once the bench inputs have settled.
  always @(posedge clk) begin
    if (memClear) begin
      memPending = 1'b0;
      memAge     = 0;
      memClear   = 1'b0;
    end else begin
      if (memPending && memRvalid) memPending = 1'b0;
      else if (memPending && memRvCnt > 0) memRvCnt = memRvCnt - 1;
      if (imemBus.imem_req && memGnt) begin
        memPending = 1'b1;
        memAddr    = imemBus.imem_addr;
        memRvCnt   = rvDelay - 1;
        memAge     = 0;
      end else if (imemBus.imem_req) begin
        memAge = memAge + 1;
      end else begin
        memAge = 0;
      end
    end
    #2;
    memGnt    = imemBus.imem_req && !memPending && (memAge >= gntDelay);
    memRvalid = memPending && (memRvCnt == 0);
    memRdata  = memRvalid ? memAddr + 32'h13 : 32'd0;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycN(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Leaves the bench 1 time unit after the edge that starts cycle C0.
  task automatic doReset();
    cyc();
    rst = 1'b1; suspend = 1'b0; flush = 1'b0; redirect = 1'b0; redirectPc = 32'd0;
    gntDelay = 0; rvDelay = 1; memClear = 1'b1;
    cycN(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    #3;
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL rst_req: got %b want 0", imemBus.imem_req); else passCnt++;
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", ifValid); else passCnt++;
    totalCnt++; if (ifInst !== 32'd0) $display("[TB] FAIL rst_inst: got %h want 0", ifInst); else passCnt++;
    totalCnt++; if (ifPc !== 32'd0) $display("[TB] FAIL rst_pc: got %h want 0", ifPc); else passCnt++;
    totalCnt++; if (ifPc4 !== 32'd0) $display("[TB] FAIL rst_pc4: got %h want 0", ifPc4); else passCnt++;
    cyc(); rst = 1'b0;  // C0, IDLE
    #3;
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL idle_req: got %b want 0", imemBus.imem_req); else passCnt++;
  endtask

  // Continues from C0 of test_reset with zero-wait memory.
  task automatic test_zero_wait();
    cyc(); #3;  // C1
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h0) $display("[TB] FAIL zw_req0: got %b/%h want 1/00000000", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); #3;  // C2
    totalCnt++; if (ifValid !== 1'b0 || imemBus.imem_req !== 1'b0) $display("[TB] FAIL zw_wait: got valid %b req %b want 0/0", ifValid, imemBus.imem_req); else passCnt++;
    cyc(); #3;  // C3
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInst !== 32'h13 || ifPc4 !== 32'h4) $display("[TB] FAIL zw_slot0: got %b %h %h %h want 1 00000000 00000013 00000004", ifValid, ifPc, ifInst, ifPc4); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h4) $display("[TB] FAIL zw_req4: got %b/%h want 1/00000004", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); #3;  // C4
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL zw_release: got %b want 0", ifValid); else passCnt++;
    cyc(); #3;  // C5
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInst !== 32'h17 || ifPc4 !== 32'h8) $display("[TB] FAIL zw_slot4: got %b %h %h %h want 1 00000004 00000017 00000008", ifValid, ifPc, ifInst, ifPc4); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h8) $display("[TB] FAIL zw_req8: got %b/%h want 1/00000008", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(2); #3;  // C7
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h8 || ifInst !== 32'h1B || ifPc4 !== 32'hC) $display("[TB] FAIL zw_slot8: got %b %h %h %h want 1 00000008 0000001b 0000000c", ifValid, ifPc, ifInst, ifPc4); else passCnt++;
  endtask

  task automatic test_slow_memory();
    doReset();
    gntDelay = 3; rvDelay = 2;
    for (int c = 1; c <= 4; c++) begin  // C1..C4, grant in C4
      cyc(); #3;
      totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h0) $display("[TB] FAIL slow_hold0_c%0d: got %b/%h want 1/00000000", c, imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    end
    cyc(); #3;  // C5
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL slow_wait_req: got %b want 0", imemBus.imem_req); else passCnt++;
    cyc(); #3;  // C6, response in flight
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL slow_early_valid: got %b want 0", ifValid); else passCnt++;
    cyc(); #3;  // C7
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInst !== 32'h13) $display("[TB] FAIL slow_slot0: got %b %h %h want 1 00000000 00000013", ifValid, ifPc, ifInst); else passCnt++;
    cycN(2); #3;  // C9, still waiting for grant
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h4) $display("[TB] FAIL slow_hold4: got %b/%h want 1/00000004", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(4); #3;  // C13
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInst !== 32'h17 || ifPc4 !== 32'h8) $display("[TB] FAIL slow_slot4: got %b %h %h %h want 1 00000004 00000017 00000008", ifValid, ifPc, ifInst, ifPc4); else passCnt++;
  endtask

  task automatic test_suspend();
    doReset();
    cycN(3); suspend = 1'b1;  // C3, slot holds pc 0
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      #3;
      totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL susp_req_%0d: got %b want 0", c, imemBus.imem_req); else passCnt++;
      totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInst !== 32'h13) $display("[TB] FAIL susp_slot_%0d: got %b %h %h want 1 00000000 00000013", c, ifValid, ifPc, ifInst); else passCnt++;
    end
    cyc(); suspend = 1'b0; #3;  // C7
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h4) $display("[TB] FAIL susp_resume_req: got %b/%h want 1/00000004", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); #3;  // C8
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL susp_consume: got %b want 0", ifValid); else passCnt++;
    cyc(); #3;  // C9
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInst !== 32'h17) $display("[TB] FAIL susp_next: got %b %h %h want 1 00000004 00000017", ifValid, ifPc, ifInst); else passCnt++;
  endtask

  task automatic test_redirect_wait();
    doReset();
    rvDelay = 3;
    cycN(9); #3;  // C9, request for 8
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h8) $display("[TB] FAIL rdw_req8: got %b/%h want 1/00000008", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); redirect = 1'b1; redirectPc = 32'h100; #3;  // C10, WAIT for 8
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL rdw_req_c10: got %b want 0", imemBus.imem_req); else passCnt++;
    cyc(); redirect = 1'b0; #3;  // C11
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL rdw_req_c11: got %b want 0", imemBus.imem_req); else passCnt++;
    cyc(); #3;  // C12, stale response arrives
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL rdw_req_c12: got %b want 0", imemBus.imem_req); else passCnt++;
    cyc(); #3;  // C13
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h100) $display("[TB] FAIL rdw_req100: got %b/%h want 1/00000100", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    for (int c = 13; c <= 16; c++) begin
      if (c > 13) cyc();
      #3;
      totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL rdw_stale_c%0d: got valid %b inst %h want 0", c, ifValid, ifInst); else passCnt++;
    end
    cyc(); #3;  // C17
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h100 || ifInst !== 32'h113 || ifPc4 !== 32'h104) $display("[TB] FAIL rdw_slot100: got %b %h %h %h want 1 00000100 00000113 00000104", ifValid, ifPc, ifInst, ifPc4); else passCnt++;
  endtask

  task automatic test_flush_redirect();
    doReset();
    cycN(3); suspend = 1'b1; flush = 1'b1; #3;  // C3
    totalCnt++; if (ifValid !== 1'b1) $display("[TB] FAIL fl_pre_valid: got %b want 1", ifValid); else passCnt++;
    cyc(); flush = 1'b0; suspend = 1'b0; #3;  // C4
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL fl_valid: got %b want 0", ifValid); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h4) $display("[TB] FAIL fl_req4: got %b/%h want 1/00000004", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); redirect = 1'b1; redirectPc = 32'h40; #3;  // C5, response for 4 coincides
    cyc(); redirect = 1'b0; #3;  // C6
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL rdv_drop: got valid %b inst %h want 0", ifValid, ifInst); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h40) $display("[TB] FAIL rdv_req40: got %b/%h want 1/00000040", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(2); #3;  // C8
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h40 || ifInst !== 32'h53) $display("[TB] FAIL rdv_slot40: got %b %h %h want 1 00000040 00000053", ifValid, ifPc, ifInst); else passCnt++;
  endtask

  task automatic test_wrap();
    doReset();
    cyc(); redirect = 1'b1; redirectPc = 32'hFFFF_FFFC; #3;  // C1
    totalCnt++; if (imemBus.imem_req !== 1'b0) $display("[TB] FAIL wrap_redir_req: got %b want 0", imemBus.imem_req); else passCnt++;
    cyc(); redirect = 1'b0; #3;  // C2
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_req: got %b/%h want 1/fffffffc", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(2); #3;  // C4
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'hFFFF_FFFC || ifPc4 !== 32'h0 || ifInst !== 32'hF) $display("[TB] FAIL wrap_slot: got %b %h %h %h want 1 fffffffc 00000000 0000000f", ifValid, ifPc, ifPc4, ifInst); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h0) $display("[TB] FAIL wrap_next: got %b/%h want 1/00000000", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
  endtask

  task automatic test_misalign();
    doReset();
    cyc(); redirect = 1'b1; redirectPc = 32'h102; #3;  // C1
`ifdef IF_MISALIGN_EN
    for (int c = 2; c <= 4; c++) begin
      cyc(); redirect = 1'b0; #3;
      totalCnt++; if (imemBus.imem_req !== 1'b0 || ifMisalign !== 1'b1) $display("[TB] FAIL mis_fault_c%0d: got req %b mis %b want 0/1", c, imemBus.imem_req, ifMisalign); else passCnt++;
    end
    cyc(); redirect = 1'b1; redirectPc = 32'h200; #3;  // C5
    cyc(); redirect = 1'b0; #3;  // C6
    totalCnt++; if (ifMisalign !== 1'b0) $display("[TB] FAIL mis_clear: got %b want 0", ifMisalign); else passCnt++;
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h200) $display("[TB] FAIL mis_resume: got %b/%h want 1/00000200", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(2); #3;  // C8
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h200 || ifInst !== 32'h213) $display("[TB] FAIL mis_slot: got %b %h %h want 1 00000200 00000213", ifValid, ifPc, ifInst); else passCnt++;
`else
    cyc(); redirect = 1'b0; #3;  // C2
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h100) $display("[TB] FAIL align_req: got %b/%h want 1/00000100", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cycN(2); #3;  // C4
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h100 || ifPc4 !== 32'h104 || ifInst !== 32'h113) $display("[TB] FAIL align_slot: got %b %h %h %h want 1 00000100 00000104 00000113", ifValid, ifPc, ifPc4, ifInst); else passCnt++;
`endif
  endtask

  task automatic test_reset_midwait();
    doReset();
    rvDelay = 3;
    cycN(2); rst = 1'b1; #3;  // C2, reset while waiting for addr 0
    totalCnt++; if (imemBus.imem_req !== 1'b0 || ifValid !== 1'b0) $display("[TB] FAIL mid_rst: got req %b valid %b want 0/0", imemBus.imem_req, ifValid); else passCnt++;
    cyc(); rst = 1'b0; rvDelay = 1; #3;  // C3, IDLE
    cyc(); #3;  // C4, late response arrives while in REQ
    totalCnt++; if (imemBus.imem_req !== 1'b1 || imemBus.imem_addr !== 32'h0) $display("[TB] FAIL mid_req: got %b/%h want 1/00000000", imemBus.imem_req, imemBus.imem_addr); else passCnt++;
    cyc(); #3;  // C5
    totalCnt++; if (ifValid !== 1'b0) $display("[TB] FAIL mid_late_ignored: got %b want 0", ifValid); else passCnt++;
    cycN(2); #3;  // C7
    totalCnt++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInst !== 32'h13) $display("[TB] FAIL mid_slot: got %b %h %h want 1 00000000 00000013", ifValid, ifPc, ifInst); else passCnt++;
  endtask

  // Tests run back to back; test_zero_wait continues test_reset's timeline.
  initial begin
    $display("[TB] if_fetch_unit directed tests start");
    test_reset();
    test_zero_wait();
    test_slow_memory();
    test_suspend();
    test_redirect_wait();
    test_flush_redirect();
    test_wrap();
    test_misalign();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
